ebus_dev_port: RTL and testbench

EBUS_DEV_PORT -- requirements
Module: ebus_dev_port

---
 rtl/ebus_dev_port.sv | 165 ++++++++++++++++
 tb/tb_ebus_dev_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_dev_port.sv
// EBUS device port: answers CONO/CONI/DATAO/DATAI for one controller select
// and serves priority interrupts on a CONO-programmed PI level.
module ebus_dev_port #(
    parameter logic [0:6]  DEV_CS    = 7'o060,
    parameter logic [0:17] PI_VECTOR = 18'o000040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:6]  ebusCS,
    input  logic [0:2]  ebusFunc,
    input  logic        ebusDemand,
    input  logic [0:35] ebusData,
    input  logic        ebusReset,
    output logic [0:36] drv,
    output logic        ebusAck,
    output logic        ebusXfer,
    output logic [0:7]  ebusPI,
    input  logic [0:35] devConiWord,
    input  logic [0:35] devDataiWord,
    input  logic        devIntReq,
    output logic [0:35] devConoWord,
    output logic        devConoStb,
    output logic [0:35] devDataoWord,
    output logic        devDataoStb,
    output logic        devDataiStb,
    output logic        devIntAck
);

    localparam logic [0:2] FN_CONO    = 3'b000;
    localparam logic [0:2] FN_CONI    = 3'b001;
    localparam logic [0:2] FN_DATAO   = 3'b010;
    localparam logic [0:2] FN_DATAI   = 3'b011;
    localparam logic [0:2] FN_PISERV  = 3'b100;
    localparam logic [0:2] FN_PIADDR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER     = 2'd1,
        ST_WAITDROP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [0:2]  pi_level_q;
    logic [0:2]  pi_level_d;
    logic        rst_any;
    logic        sel_go;
    logic        pi_go;
    logic [0:36] drv_d;
    logic        ack_d;
    logic [0:35] cono_word_d;
    logic [0:35] datao_word_d;
    logic        cono_stb_d;
    logic        datao_stb_d;
    logic        datai_stb_d;
    logic        int_ack_d;

    assign rst_any = reset | ebusReset;

    // Functions 110/111 fall out of sel_go because only codes 0xx are I/O transfers.
    assign sel_go = (state_q == ST_IDLE) && ebusDemand && (ebusCS == DEV_CS)
                    && (ebusFunc[0] == 1'b0);

    // PI cycles decode only the level field; the controller-number bits are ignored.
    assign pi_go = (state_q == ST_IDLE) && ebusDemand && devIntReq
                   && ((ebusFunc == FN_PISERV) || (ebusFunc == FN_PIADDR))
                   && (pi_level_q != 3'd0) && (ebusCS[4:6] == pi_level_q);

    always_ff @(posedge clk) begin
        if (rst_any) begin
            state_q      <= ST_IDLE;
            pi_level_q   <= '0;
            drv          <= '0;
            ebusAck      <= 1'b0;
            ebusXfer     <= 1'b0;
            devConoWord  <= '0;
            devDataoWord <= '0;
            devConoStb   <= 1'b0;
            devDataoStb  <= 1'b0;
            devDataiStb  <= 1'b0;
            devIntAck    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pi_level_q   <= pi_level_d;
            drv          <= drv_d;
            ebusAck      <= ack_d;
            ebusXfer     <= ack_d;
            devConoWord  <= cono_word_d;
            devDataoWord <= datao_word_d;
            devConoStb   <= cono_stb_d;
            devDataoStb  <= datao_stb_d;
            devDataiStb  <= datai_stb_d;
            devIntAck    <= int_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (sel_go || pi_go) state_d = ST_XFER;
            ST_XFER:     if (!ebusDemand) state_d = ST_WAITDROP;
            ST_WAITDROP: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // drv_d is only ever non-zero together with the driving bit, keeping the bus wired-OR safe.
    always_comb begin
        drv_d        = '0;
        ack_d        = 1'b0;
        cono_word_d  = devConoWord;
        datao_word_d = devDataoWord;
        pi_level_d   = pi_level_q;
        cono_stb_d   = 1'b0;
        datao_stb_d  = 1'b0;
        datai_stb_d  = 1'b0;
        int_ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_go) begin
                    ack_d = 1'b1;
                    case (ebusFunc)
                        FN_CONO: begin
                            cono_word_d = ebusData;
                            pi_level_d  = ebusData[33:35];
                            cono_stb_d  = 1'b1;
                        end
                        FN_CONI: drv_d = {devConiWord, 1'b1};
                        FN_DATAO: begin
                            datao_word_d = ebusData;
                            datao_stb_d  = 1'b1;
                        end
                        FN_DATAI: begin
                            drv_d       = {devDataiWord, 1'b1};
                            datai_stb_d = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (pi_go) begin
                    ack_d = 1'b1;
                    if (ebusFunc == FN_PIADDR) begin
                        drv_d = {18'b0, PI_VECTOR, 1'b1};
                    end else begin
                        int_ack_d = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (ebusDemand) begin
                    ack_d = 1'b1;
                    drv_d = drv;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ebusPI = '0;
        if (devIntReq && (pi_level_q != 3'd0)) begin
            ebusPI[pi_level_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_ebus_dev_port.sv
// Scoreboard bench for ebus_dev_port: expected words queued at stimulus time,
// popped and compared when the port responds.
module tb_ebus_dev_port;

    localparam logic [0:6] DEV_CS = 7'o060;
    localparam logic [0:2] F_CONO = 3'b000, F_CONI = 3'b001, F_DATAO = 3'b010, F_DATAI = 3'b011;
    localparam logic [0:2] F_PISERV = 3'b100, F_PIADDR = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:6]  ebusCS;
    logic [0:2]  ebusFunc;
    logic        ebusDemand;
    logic [0:35] ebusData;
    logic        ebusReset;
    logic [0:36] drv;
    logic        ebusAck;
    logic        ebusXfer;
    logic [0:7]  ebusPI;
    logic [0:35] devConiWord;
    logic [0:35] devDataiWord;
    logic        devIntReq;
    logic [0:35] devConoWord;
    logic        devConoStb;
    logic [0:35] devDataoWord;
    logic        devDataoStb;
    logic        devDataiStb;
    logic        devIntAck;

    int n_checks = 0;
    int n_fail = 0;
    int cono_cnt = 0, datao_cnt = 0, datai_cnt = 0, intack_cnt = 0;

    logic [0:35] exp_word_q[$];
    logic [0:36] exp_drv_q[$];

    ebus_dev_port #(.DEV_CS(7'o060), .PI_VECTOR(18'o000040)) dut (
        .clk(clk), .reset(reset), .ebusCS(ebusCS), .ebusFunc(ebusFunc),
        .ebusDemand(ebusDemand), .ebusData(ebusData), .ebusReset(ebusReset),
        .drv(drv), .ebusAck(ebusAck), .ebusXfer(ebusXfer), .ebusPI(ebusPI),
        .devConiWord(devConiWord), .devDataiWord(devDataiWord), .devIntReq(devIntReq),
        .devConoWord(devConoWord), .devConoStb(devConoStb),
        .devDataoWord(devDataoWord), .devDataoStb(devDataoStb),
        .devDataiStb(devDataiStb), .devIntAck(devIntAck)
    );

    always #5 clk = ~clk;

    // Strobes are registered, so sampling at posedge sees the pulse of the cycle just ended.
    always @(posedge clk) begin
        cono_cnt   += int'(devConoStb);
        datao_cnt  += int'(devDataoStb);
        datai_cnt  += int'(devDataiStb);
        intack_cnt += int'(devIntAck);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [0:6] cs, input logic [0:2] f, input logic [0:35] d, input logic dem);
        ebusCS = cs; ebusFunc = f; ebusData = d; ebusDemand = dem;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (ebusAck !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ebusAck); end
        n_checks++; if (ebusXfer !== 1'b0) begin n_fail++; $display("FAIL reset_xfer: got %b expected 0", ebusXfer); end
        n_checks++; if (drv !== 37'b0) begin n_fail++; $display("FAIL reset_drv: got %o expected 0", drv); end
        n_checks++; if (devConoWord !== 36'b0) begin n_fail++; $display("FAIL reset_cono_word: got %o expected 0", devConoWord); end
        n_checks++; if (devDataoWord !== 36'b0) begin n_fail++; $display("FAIL reset_datao_word: got %o expected 0", devDataoWord); end
        n_checks++; if ({devConoStb, devDataoStb, devDataiStb, devIntAck} !== 4'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {devConoStb, devDataoStb, devDataiStb, devIntAck}); end
        reset = 1'b0;
        devIntReq = 1'b1;
        @(negedge clk);
        n_checks++; if (ebusPI !== 8'b0) begin n_fail++; $display("FAIL reset_pi_disabled: got %b expected 00000000", ebusPI); end
        devIntReq = 1'b0;
    endtask

    task automatic test_cono();
        int c0;
        logic [0:35] w;
        c0 = cono_cnt;
        exp_word_q.push_back(36'o000000_000005);
        drive(DEV_CS, F_CONO, 36'o000000_000005, 1'b1);
        @(negedge clk);
        n_checks++; if (devConoStb !== 1'b1) begin n_fail++; $display("FAIL cono_stb_n1: got %b expected 1", devConoStb); end
        n_checks++; if ({ebusAck, ebusXfer} !== 2'b11) begin n_fail++; $display("FAIL cono_ack_n1: got %b expected 11", {ebusAck, ebusXfer}); end
        w = exp_word_q.pop_front();
        n_checks++; if (devConoWord !== w) begin n_fail++; $display("FAIL cono_word: got %o expected %o", devConoWord, w); end
        @(negedge clk);
        n_checks++; if (devConoStb !== 1'b0) begin n_fail++; $display("FAIL cono_stb_n2: got %b expected 0", devConoStb); end
        @(negedge clk);
        n_checks++; if ({ebusAck, ebusXfer} !== 2'b11) begin n_fail++; $display("FAIL cono_ack_n3: got %b expected 11", {ebusAck, ebusXfer}); end
        ebusDemand = 1'b0;
        @(negedge clk);
        n_checks++; if ({ebusAck, ebusXfer, drv[36]} !== 3'b000) begin
            n_fail++; $display("FAIL cono_waitdrop: got %b expected 000", {ebusAck, ebusXfer, drv[36]}); end
        @(negedge clk);
        n_checks++; if (cono_cnt - c0 !== 1) begin n_fail++; $display("FAIL cono_one_pulse: got %0d expected 1", cono_cnt - c0); end
        devIntReq = 1'b1;
        #1;
        n_checks++; if (ebusPI !== 8'b0000_0100) begin n_fail++; $display("FAIL cono_pi_level5: got %b expected 00000100", ebusPI); end
        devIntReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_datai();
        int c0;
        logic [0:36] e;
        c0 = datai_cnt;
        devDataiWord = 36'o123456_654321;
        exp_drv_q.push_back({36'o123456_654321, 1'b1});
        drive(DEV_CS, F_DATAI, 36'o777777_777777, 1'b1);
        @(negedge clk);
        e = exp_drv_q.pop_front();
        n_checks++; if (drv !== e) begin n_fail++; $display("FAIL datai_drv_n1: got %o expected %o", drv, e); end
        n_checks++; if (devDataiStb !== 1'b1) begin n_fail++; $display("FAIL datai_stb_n1: got %b expected 1", devDataiStb); end
        devDataiWord = 36'o111111_222222;
        @(negedge clk);
        n_checks++; if (drv !== e) begin n_fail++; $display("FAIL datai_drv_held: got %o expected %o", drv, e); end
        n_checks++; if (devDataiStb !== 1'b0) begin n_fail++; $display("FAIL datai_stb_n2: got %b expected 0", devDataiStb); end
        ebusDemand = 1'b0;
        @(negedge clk);
        n_checks++; if (drv !== 37'b0) begin n_fail++; $display("FAIL datai_waitdrop_drv: got %o expected 0", drv); end
        @(negedge clk);
        n_checks++; if (datai_cnt - c0 !== 1) begin n_fail++; $display("FAIL datai_one_pulse: got %0d expected 1", datai_cnt - c0); end
    endtask

    task automatic test_datao_coni();
        logic [0:35] w;
        logic [0:36] e;
        exp_word_q.push_back(36'o707070_123123);
        drive(DEV_CS, F_DATAO, 36'o707070_123123, 1'b1);
        @(negedge clk);
        w = exp_word_q.pop_front();
        n_checks++; if (devDataoStb !== 1'b1) begin n_fail++; $display("FAIL datao_stb: got %b expected 1", devDataoStb); end
        n_checks++; if (devDataoWord !== w) begin n_fail++; $display("FAIL datao_word: got %o expected %o", devDataoWord, w); end
        n_checks++; if (drv !== 37'b0) begin n_fail++; $display("FAIL datao_no_drive: got %o expected 0", drv); end
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
        devConiWord = 36'o246024_602460;
        exp_drv_q.push_back({36'o246024_602460, 1'b1});
        drive(DEV_CS, F_CONI, 36'o0, 1'b1);
        @(negedge clk);
        e = exp_drv_q.pop_front();
        n_checks++; if (drv !== e) begin n_fail++; $display("FAIL coni_drv: got %o expected %o", drv, e); end
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [0:36] e;
        devDataiWord = 36'o000111_000222;
        drive(DEV_CS, F_DATAI, 36'o0, 1'b1);
        @(negedge clk);
        ebusDemand = 1'b0;
        @(negedge clk);
        devConiWord = 36'o555000_000555;
        exp_drv_q.push_back({36'o555000_000555, 1'b1});
        drive(DEV_CS, F_CONI, 36'o0, 1'b1);
        @(negedge clk);
        n_checks++; if (ebusAck !== 1'b0) begin n_fail++; $display("FAIL b2b_dead_cycle: got %b expected 0", ebusAck); end
        @(negedge clk);
        e = exp_drv_q.pop_front();
        n_checks++; if (ebusAck !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack: got %b expected 1", ebusAck); end
        n_checks++; if (drv !== e) begin n_fail++; $display("FAIL b2b_second_drv: got %o expected %o", drv, e); end
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pi();
        int c0;
        logic [0:36] e;
        drive(DEV_CS, F_CONO, 36'o000000_000003, 1'b1);
        @(negedge clk);
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
        devIntReq = 1'b1;
        #1;
        n_checks++; if (ebusPI !== 8'b0001_0000) begin n_fail++; $display("FAIL pi_lines_l3: got %b expected 00010000", ebusPI); end
        exp_drv_q.push_back({36'o000000_000040, 1'b1});
        drive({4'b1010, 3'd3}, F_PIADDR, 36'o0, 1'b1);
        @(negedge clk);
        e = exp_drv_q.pop_front();
        n_checks++; if (drv !== e) begin n_fail++; $display("FAIL pi_vector_drv: got %o expected %o", drv, e); end
        n_checks++; if (ebusAck !== 1'b1) begin n_fail++; $display("FAIL pi_addr_ack: got %b expected 1", ebusAck); end
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
        c0 = intack_cnt;
        drive({4'b0000, 3'd3}, F_PISERV, 36'o0, 1'b1);
        @(negedge clk);
        n_checks++; if ({devIntAck, ebusAck, drv[36]} !== 3'b110) begin
            n_fail++; $display("FAIL pi_served: got %b expected 110", {devIntAck, ebusAck, drv[36]}); end
        @(negedge clk);
        n_checks++; if (devIntAck !== 1'b0) begin n_fail++; $display("FAIL pi_served_n2: got %b expected 0", devIntAck); end
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (intack_cnt - c0 !== 1) begin n_fail++; $display("FAIL pi_served_one_pulse: got %0d expected 1", intack_cnt - c0); end
        drive({4'b0000, 3'd2}, F_PIADDR, 36'o0, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if ({ebusAck, drv[36]} !== 2'b00) begin n_fail++; $display("FAIL pi_wrong_level: got %b expected 00", {ebusAck, drv[36]}); end
        ebusDemand = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_response();
        int c0;
        logic [0:6] cs_tab[3];
        logic [0:2] fn_tab[3];
        cs_tab = '{DEV_CS + 7'd1, DEV_CS, DEV_CS};
        fn_tab = '{F_CONO, 3'b111, 3'b110};
        for (int i = 0; i < 3; i++) begin
            c0 = cono_cnt + datao_cnt + datai_cnt + intack_cnt;
            drive(cs_tab[i], fn_tab[i], 36'o000000_000007, 1'b1);
            repeat (3) @(negedge clk);
            n_checks++; if ({ebusAck, ebusXfer, drv[36]} !== 3'b000) begin
                n_fail++; $display("FAIL no_resp_%0d: got %b expected 000", i, {ebusAck, ebusXfer, drv[36]}); end
            ebusDemand = 1'b0;
            @(negedge clk);
            n_checks++; if (cono_cnt + datao_cnt + datai_cnt + intack_cnt - c0 !== 0) begin
                n_fail++; $display("FAIL no_resp_strobe_%0d: got %0d expected 0", i, cono_cnt + datao_cnt + datai_cnt + intack_cnt - c0); end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        logic [0:35] w;
        drive(DEV_CS, F_DATAO, 36'o000000_000001, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({ebusAck, ebusXfer} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ack: got %b expected 00", {ebusAck, ebusXfer}); end
        n_checks++; if (ebusPI !== 8'b0) begin n_fail++; $display("FAIL rstmid_pilevel: got %b expected 00000000", ebusPI); end
        n_checks++; if (devDataoWord !== 36'b0) begin n_fail++; $display("FAIL rstmid_word: got %o expected 0", devDataoWord); end
        c0 = datao_cnt;
        @(negedge clk);
        n_checks++; if ({ebusAck, devDataoStb} !== 2'b00) begin n_fail++; $display("FAIL rstmid_override: got %b expected 00", {ebusAck, devDataoStb}); end
        reset = 1'b0;
        exp_word_q.push_back(36'o000000_000001);
        @(negedge clk);
        w = exp_word_q.pop_front();
        n_checks++; if ({ebusAck, devDataoStb} !== 2'b11) begin n_fail++; $display("FAIL rstmid_rematch: got %b expected 11", {ebusAck, devDataoStb}); end
        n_checks++; if (devDataoWord !== w) begin n_fail++; $display("FAIL rstmid_rematch_word: got %o expected %o", devDataoWord, w); end
        n_checks++; if (datao_cnt - c0 !== 0) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d expected 0", datao_cnt - c0); end
        ebusReset = 1'b1;
        @(negedge clk);
        n_checks++; if ({ebusAck, drv[36]} !== 2'b00) begin n_fail++; $display("FAIL ebusreset_mid: got %b expected 00", {ebusAck, drv[36]}); end
        ebusReset = 1'b0;
        ebusDemand = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ebusReset = 1'b0; devIntReq = 1'b0;
        devConiWord = '0; devDataiWord = '0;
        drive(7'd0, 3'd0, 36'd0, 1'b0);
        @(negedge clk);
        test_reset();
        test_cono();
        test_datai();
        test_datao_coni();
        test_back_to_back();
        test_pi();
        test_no_response();
        test_reset_mid();
        n_checks++; if (exp_word_q.size() + exp_drv_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_word_q.size() + exp_drv_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
